// File: rtl/imm_gen_ctrl.sv
// Immediate-generation decode stage: classifies RV32I instructions, builds the
// sign-extended immediate and buffers results in a 2-entry FIFO with valid/ready.
module imm_gen_ctrl #(
  parameter int TAG_W = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      imm,
  output logic [2:0]       fmt,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [31:0]      imm_mem_q [0:1];
  logic [31:0]      imm_mem_d [0:1];
  logic [2:0]       fmt_mem_q [0:1];
  logic [2:0]       fmt_mem_d [0:1];
  logic [TAG_W-1:0] tag_mem_q [0:1];
  logic [TAG_W-1:0] tag_mem_d [0:1];
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [6:0]  opcode;
  logic [31:0] dec_imm;
  logic [2:0]  dec_fmt;
  logic        push;
  logic        pop;

  assign opcode = instr[6:0];

  always_comb begin
    dec_imm = 32'd0;
    dec_fmt = FMT_ILL;
    case (opcode)
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        dec_imm = {{20{instr[31]}}, instr[31:20]};
        dec_fmt = FMT_I;
      end
      7'b0100011: begin
        dec_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        dec_fmt = FMT_S;
      end
      7'b1100011: begin
        dec_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        dec_fmt = FMT_B;
      end
      7'b0110111, 7'b0010111: begin
        dec_imm = {instr[31:12], 12'b0};
        dec_fmt = FMT_U;
      end
      7'b1101111: begin
        dec_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        dec_fmt = FMT_J;
      end
      7'b0110011: begin
        dec_imm = 32'd0;
        dec_fmt = FMT_R;
      end
      default: begin
        dec_imm = 32'd0;
        dec_fmt = FMT_ILL;
      end
    endcase
  end

  // Handshake flags come purely from registered occupancy, so in_ready never
  // combinationally depends on out_ready.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (push) state_d = ST_ONE;
      ST_ONE: begin
        if (push && !pop)      state_d = ST_FULL;
        else if (pop && !push) state_d = ST_EMPTY;
      end
      ST_FULL:  if (pop) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    imm_mem_d = imm_mem_q;
    fmt_mem_d = fmt_mem_q;
    tag_mem_d = tag_mem_q;
    err_cnt_d = err_cnt_q;
    if (push) begin
      imm_mem_d[wr_ptr_q] = dec_imm;
      fmt_mem_d[wr_ptr_q] = dec_fmt;
      tag_mem_d[wr_ptr_q] = in_tag;
      wr_ptr_d            = ~wr_ptr_q;
      if (dec_fmt == FMT_ILL && err_cnt_q != CNT_MAX) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  // Clearing the entry storage makes the head read back as zero after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_EMPTY;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      imm_mem_q[0] <= 32'd0;
      imm_mem_q[1] <= 32'd0;
      fmt_mem_q[0] <= 3'd0;
      fmt_mem_q[1] <= 3'd0;
      tag_mem_q[0] <= '0;
      tag_mem_q[1] <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      imm_mem_q <= imm_mem_d;
      fmt_mem_q <= fmt_mem_d;
      tag_mem_q <= tag_mem_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign imm     = imm_mem_q[rd_ptr_q];
  assign fmt     = fmt_mem_q[rd_ptr_q];
  assign out_tag = tag_mem_q[rd_ptr_q];
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_imm_gen_ctrl.sv
// Directed self-checking bench for imm_gen_ctrl: decode of each format, FIFO
// ordering under back-pressure, illegal-opcode counter saturation, async reset.
module tb_imm_gen_ctrl;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] imm;
  logic [2:0]  fmt;
  logic [31:0] out_tag;
  logic [7:0]  err_cnt;

  int vectors;
  int miscompares;

  imm_gen_ctrl #(.TAG_W(32), .CNT_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .instr    (instr),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .imm      (imm),
    .fmt      (fmt),
    .out_tag  (out_tag),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are read 2 time units later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] i,
                               input logic [31:0] t, input logic r);
    in_valid  = v;
    instr     = i;
    in_tag    = t;
    out_ready = r;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, observed, expected);
    end
  endtask

  task automatic checkHead(input string name, input logic [31:0] e_imm,
                           input logic [2:0] e_fmt, input logic [31:0] e_tag);
    checkOutput({name, ".valid"}, 32'(out_valid), 32'd1);
    checkOutput({name, ".imm"}, imm, e_imm);
    checkOutput({name, ".fmt"}, 32'(fmt), 32'(e_fmt));
    checkOutput({name, ".tag"}, out_tag, e_tag);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
    #3;
    checkOutput("rst.out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst.in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst.imm", imm, 32'd0);
    checkOutput("rst.fmt", 32'(fmt), 32'd0);
    checkOutput("rst.out_tag", out_tag, 32'd0);
    checkOutput("rst.err_cnt", 32'(err_cnt), 32'd0);
    #4;
    reset = 1'b0;

    // sw x5,8(x2)
    applyStimulus(1'b1, 32'h0051_2423, 32'h100, 1'b1);
    step();
    checkHead("sw", 32'h0000_0008, 3'd2, 32'h100);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
    step();
    checkOutput("sw.drain", 32'(out_valid), 32'd0);

    // beq then jal back-to-back, consumer always ready
    applyStimulus(1'b1, 32'hFE00_0EE3, 32'h104, 1'b1);
    step();
    checkHead("beq", 32'hFFFF_FFFC, 3'd3, 32'h104);
    applyStimulus(1'b1, 32'hFF9F_F0EF, 32'h108, 1'b1);
    step();
    checkHead("jal", 32'hFFFF_FFF8, 3'd5, 32'h108);

    // lui, addi -1, add (R-type), lw x1,0x7FF(x0)
    applyStimulus(1'b1, 32'h1234_50B7, 32'h10C, 1'b1);
    step();
    checkHead("lui", 32'h1234_5000, 3'd4, 32'h10C);
    applyStimulus(1'b1, 32'hFFF0_0093, 32'h110, 1'b1);
    step();
    checkHead("addi", 32'hFFFF_FFFF, 3'd1, 32'h110);
    applyStimulus(1'b1, 32'h0020_81B3, 32'h114, 1'b1);
    step();
    checkHead("add", 32'h0000_0000, 3'd0, 32'h114);
    applyStimulus(1'b1, 32'h7FF0_2083, 32'h118, 1'b1);
    step();
    checkHead("lw", 32'h0000_07FF, 3'd1, 32'h118);
    checkOutput("lw.err_cnt", 32'(err_cnt), 32'd0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
    step();
    checkOutput("drain1", 32'(out_valid), 32'd0);

    // Back-pressure: addi imm 1,2,3 with tags 0x10,0x14,0x18
    applyStimulus(1'b1, 32'h0010_0013, 32'h10, 1'b0);
    step();
    checkHead("bp1", 32'd1, 3'd1, 32'h10);
    checkOutput("bp1.in_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, 32'h0020_0013, 32'h14, 1'b0);
    step();
    checkHead("bp2", 32'd1, 3'd1, 32'h10);
    checkOutput("bp2.in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 32'h0030_0013, 32'h18, 1'b0);
    step();
    checkHead("bp3.hold", 32'd1, 3'd1, 32'h10);
    checkOutput("bp3.in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 32'h0030_0013, 32'h18, 1'b1);
    step();
    checkHead("bp.pop1", 32'd2, 3'd1, 32'h14);
    checkOutput("bp.pop1.in_ready", 32'(in_ready), 32'd1);
    step();
    checkHead("bp.pop2", 32'd3, 3'd1, 32'h18);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
    step();
    checkOutput("bp.empty", 32'(out_valid), 32'd0);
    checkOutput("bp.in_ready", 32'(in_ready), 32'd1);

    // 259 illegal opcodes: counter must stop at 0xFF
    applyStimulus(1'b1, 32'h0000_007F, 32'h200, 1'b1);
    for (int n = 1; n <= 259; n++) begin
      step();
      if (n == 3)   checkOutput("ill.cnt3", 32'(err_cnt), 32'd3);
      if (n == 254) checkOutput("ill.cnt254", 32'(err_cnt), 32'd254);
      if (n == 255) checkOutput("ill.cnt255", 32'(err_cnt), 32'd255);
    end
    checkHead("ill", 32'd0, 3'd7, 32'h200);
    checkOutput("ill.sat", 32'(err_cnt), 32'hFF);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
    step();
    checkOutput("ill.empty", 32'(out_valid), 32'd0);
    checkOutput("ill.hold", 32'(err_cnt), 32'hFF);

    // Fill the FIFO, then reset asynchronously between edges
    applyStimulus(1'b1, 32'hFFF0_0093, 32'h300, 1'b0);
    step();
    applyStimulus(1'b1, 32'h1234_50B7, 32'h304, 1'b0);
    step();
    checkOutput("full.in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mrst.out_valid", 32'(out_valid), 32'd0);
    checkOutput("mrst.in_ready", 32'(in_ready), 32'd1);
    checkOutput("mrst.err_cnt", 32'(err_cnt), 32'd0);
    checkOutput("mrst.imm", imm, 32'd0);
    checkOutput("mrst.out_tag", out_tag, 32'd0);
    #1;
    reset = 1'b0;
    step();
    checkOutput("mrst.idle", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, 32'h0051_2423, 32'h400, 1'b1);
    step();
    checkHead("resume", 32'h0000_0008, 3'd2, 32'h400);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1);
    step();
    checkOutput("resume.empty", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
